i2c_tx_fifo: RTL and testbench

I2C_TX_FIFO -- requirements
Module: i2c_tx_fifo

---
 rtl/i2c_tx_fifo.sv | 106 ++++++++++
 tb/tb_i2c_tx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_tx_fifo.sv
// rtl/i2c_tx_fifo.sv - first-word-fall-through transmit byte FIFO feeding an I2C master
//
// Purpose: buffers bytes from a producer and presents the head byte to the
// I2C master's transmit interface. Flush discards contents; a sticky
// overflow flag records writes attempted while full.
//
// Ports:
//   clock     sole clock, all state updates on rising edge
//   reset     synchronous active-high reset
//   wrData    byte from the producer
//   wrValid   producer offers wrData
//   wrReady   FIFO accepts a byte this cycle (~full)
//   outData   head byte (valid only while outValid)
//   outValid  head byte present (~empty)
//   outReady  consumer takes the head byte
//   flush     discard all stored bytes
//   clearErr  clear the sticky overflow flag
//   level     number of stored bytes, 0..DEPTH
//   full      level == DEPTH
//   empty     level == 0
//   overflow  sticky: write attempted while full
module i2c_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     wrValid,
    output logic                     wrReady,
    output logic [WIDTH-1:0]         outData,
    output logic                     outValid,
    input  logic                     outReady,
    input  logic                     flush,
    input  logic                     clearErr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [LW-1:0]    levelReg;
    logic             overflowReg;

    logic push;
    logic pop;

    // Status derives only from registered level, so wrReady/outValid never
    // depend combinationally on the other side's handshake inputs.
    assign full     = (levelReg == LW'(DEPTH));
    assign empty    = (levelReg == '0);
    assign wrReady  = ~full;
    assign outValid = ~empty;
    assign outData  = mem[rdPtr];
    assign level    = levelReg;
    assign overflow = overflowReg;

    assign push = wrValid & wrReady;
    assign pop  = outReady & outValid;

    // Storage carries no reset; pointers and level define which entries are live.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            mem[wrPtr] <= wrData;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            levelReg <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (push && !pop) begin
                levelReg <= levelReg + LW'(1);
            end else if (pop && !push) begin
                levelReg <= levelReg - LW'(1);
            end
        end
    end

    // Set has priority over clear; a flushed write is not counted as an overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflowReg <= 1'b0;
        end else if (wrValid && full && !flush) begin
            overflowReg <= 1'b1;
        end else if (clearErr) begin
            overflowReg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb/tb_i2c_tx_fifo.sv - self-checking bench for i2c_tx_fifo against a queue model
module tb_i2c_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] wrData;
    logic             wrValid;
    logic             wrReady;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outReady;
    logic             flush;
    logic             clearErr;
    logic [4:0]       level;
    logic             full;
    logic             empty;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic             mOvf = 1'b0;

    i2c_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .wrData   (wrData),
        .wrValid  (wrValid),
        .wrReady  (wrReady),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .flush    (flush),
        .clearErr (clearErr),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's current contents.
    task automatic chkAll(input string tag);
        int sz;
        sz = q.size();
        chk({tag, "_level"}, 32'(level), 32'(sz));
        chk({tag, "_empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, "_full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, "_wrReady"}, 32'(wrReady), 32'(sz != DEPTH));
        chk({tag, "_outValid"}, 32'(outValid), 32'(sz != 0));
        chk({tag, "_overflow"}, 32'(overflow), 32'(mOvf));
        if (sz != 0) begin
            chk({tag, "_outData"}, 32'(outData), 32'(q[0]));
        end
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, then check.
    task automatic step(input logic r, input logic f, input logic ce,
                        input logic wv, input logic ordy, input logic [7:0] d,
                        input string tag);
        bit isFull, isEmpty;
        reset    = r;
        flush    = f;
        clearErr = ce;
        wrValid  = wv;
        outReady = ordy;
        wrData   = d;
        isFull  = (q.size() == DEPTH);
        isEmpty = (q.size() == 0);
        if (r) begin
            q.delete();
            mOvf = 1'b0;
        end else begin
            if (wv && isFull && !f) mOvf = 1'b1;
            else if (ce)            mOvf = 1'b0;
            if (f) begin
                q.delete();
            end else begin
                if (ordy && !isEmpty) void'(q.pop_front());
                if (wv && !isFull)    q.push_back(d);
            end
        end
        @(posedge clock);
        #1;
        chkAll(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 8'h00, tag);
    endtask

    initial begin
        reset = 1'b1; flush = 0; clearErr = 0; wrValid = 0; outReady = 0; wrData = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 8'h00, "rst");
        step(1, 0, 0, 0, 0, 8'h00, "rst");
        chk("rst_level", 32'(level), 0);
        chk("rst_wrReady", 32'(wrReady), 1);

        // Single byte: no bypass while empty, visible one cycle later
        wrValid = 1; wrData = 8'hA5; reset = 0; #1;
        chk("nobypass_outValid", 32'(outValid), 0);
        step(0, 0, 0, 1, 0, 8'hA5, "push1");
        chk("push1_data", 32'(outData), 32'h0A5);
        chk("push1_lvl", 32'(level), 1);
        step(0, 0, 0, 0, 1, 8'h00, "pop1");
        chk("pop1_empty", 32'(empty), 1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 8'(i), "fill");
        chk("fill_full", 32'(full), 1);
        chk("fill_lvl", 32'(level), 16);
        step(0, 0, 0, 1, 0, 8'hEE, "ovf");
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_lvl", 32'(level), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(outData), 32'(i));
            step(0, 0, 0, 0, 1, 8'h00, "drain");
        end
        step(0, 0, 1, 0, 0, 8'h00, "clr");
        chk("clr_flag", 32'(overflow), 0);

        // Steady stream at level 3 across two pointer wraps
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'($urandom), "pre3");
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 1, 1, 8'($urandom), "stream");
            chk("stream_lvl", 32'(level), 3);
        end

        // Full with simultaneous write and read: only the pop happens
        while (q.size() < DEPTH) step(0, 0, 0, 1, 0, 8'($urandom), "fill2");
        step(0, 0, 0, 1, 1, 8'h77, "fullrw");
        chk("fullrw_lvl", 32'(level), 15);
        chk("fullrw_ovf", 32'(overflow), 1);
        step(0, 0, 1, 0, 0, 8'h00, "clr2");
        chk("clr2_flag", 32'(overflow), 0);

        // Flush overrides simultaneous push and pop
        step(0, 1, 0, 0, 0, 8'h00, "flush0");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 8'($urandom), "pre5");
        step(0, 1, 0, 1, 1, 8'h5A, "flush");
        chk("flush_lvl", 32'(level), 0);
        chk("flush_empty", 32'(empty), 1);
        idle("postflush");

        // Mid-stream reset with a pending write
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 8'($urandom), "pre7");
        step(1, 0, 0, 1, 0, 8'h33, "midrst");
        chk("midrst_lvl", 32'(level), 0);
        chk("midrst_outValid", 32'(outValid), 0);
        step(0, 0, 0, 1, 0, 8'h3C, "afterrst");
        chk("afterrst_lvl", 32'(level), 1);
        chk("afterrst_data", 32'(outData), 32'h03C);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
                 8'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
